log_memory_capture: RTL and testbench
=====================================

// Module: log_memory_capture
// PURPOSE
//  Capture memory for the DSP data logger. Records a burst of N_DATA-bit samples from the receiver datapath into an on-chip RAM.
//  The register file controls it through run_log, read_log and the address port, and polls full status over GPIO.
//  Sits directly upstream of the register file: o_data_log and o_mem_full drive its i_data_log_from_mem and i_mem_full inputs.
// PARAMETERS
//  N_DATA   22  sample width (bits), equal to the register file data-log width
//  NB_ADDR  10  address width; DEPTH = 2**NB_ADDR samples (1024)
// PORTS
//  clock        in   1        system clock; all logic on its rising edge
//  i_reset      in   1        synchronous, active-high reset
//  i_run_log    in   1        run request (level); a rising edge arms a capture
//  i_read_log   in   1        read enable (level)
//  i_addr_log   in   NB_ADDR  read address
//  i_data       in   N_DATA   sample from the DSP datapath
//  i_valid      in   1        sample strobe, one cycle per sample
//  o_data_log   out  N_DATA   registered read data
//  o_mem_full   out  1        capture complete; RAM holds DEPTH valid samples
//  o_logging    out  1        high while in LOG
// BEHAVIOUR
//  Reset: state=IDLE, wr_ptr=0, r_run=0, o_mem_full=0, o_logging=0, o_data_log=0.
//   RAM contents are not cleared.
//  Run edge: r_run <= i_run_log every cycle; start = i_run_log & ~r_run.
//  FSM has three states: IDLE, LOG, FULL.
//   IDLE: start -> LOG; wr_ptr<=0.
//   LOG:
//    - o_logging=1.
//    - Each cycle with i_valid: mem[wr_ptr]<=i_data, wr_ptr<=wr_ptr+1.
//    - A write at wr_ptr==DEPTH-1 -> FULL on the next edge; wr_ptr wraps to 0; o_mem_full<=1 on that same edge.
//    - i_run_log low (abort) -> IDLE, o_mem_full stays 0, samples already written are kept.
//    - Abort takes priority over a simultaneous write: the sample is not written.
//   FULL:
//    - o_mem_full held at 1; all writes blocked; i_valid is ignored.
//    - Falling i_run_log does not leave FULL.
//    - start (new rising edge) -> LOG; o_mem_full<=0, wr_ptr<=0 (re-arm).
//  i_valid in the cycle that start is detected is not written; the first write happens in the first LOG cycle.
//  Read path:
//   - If i_read_log && o_mem_full (registered value, current cycle): o_data_log <= mem[i_addr_log].
//   - Latency is 1 clock. Any address is legal; no out-of-range case.
//   - Otherwise o_data_log holds its last value.
//   - Reads are never allowed during LOG, so there are no read/write collisions.
//  Simultaneous events:
//   - start and a read in the same FULL cycle: the read completes with old data; the state then goes to LOG.
//   - i_reset overrides everything, including mid-capture: IDLE, full cleared, wr_ptr=0.
//  Widths: wr_ptr is NB_ADDR bits with natural wrap. The sample count is implicit (full == DEPTH samples).
//  RAM: single write port, single registered read port; inferable as block RAM.
// TESTING
//  1 Reset: hold i_reset 3 cycles -> o_mem_full=0, o_logging=0, o_data_log=0.
//  2 Full capture (NB_ADDR=10):
//    - Stimulus: raise i_run_log, then 1024 i_valid pulses with i_data=index.
//    - Required: o_mem_full=1 one cycle after the 1024th write.
//    - Required: read addr 0, 511, 1023 -> 0, 511, 1023, each one cycle later.
//  3 Sparse valid: i_valid every 3rd cycle -> exactly one write per pulse; full after the 1024th pulse, not earlier.
//  4 Abort: drop i_run_log after 100 samples -> IDLE, o_mem_full=0.
//    - Reads with i_read_log=1 leave o_data_log unchanged.
//  5 Re-arm:
//    - In FULL, toggle i_run_log 0->1 -> o_mem_full=0 next cycle.
//    - Second capture with i_data=0x3FFFFF-index overwrites: addr 5 reads 0x3FFFFA.
//  6 Overflow and reset:
//    - Extra i_valid pulses in FULL -> addr 0 unchanged.
//    - i_reset at sample 50 of a capture -> IDLE, full=0, next start restarts at addr 0.

Source files
------------

// File: rtl/log_memory_capture.sv
// Capture RAM for the DSP data logger: records a burst of DEPTH samples once armed,
// then holds them read-only until the register file re-arms with a new run edge.
module log_memory_capture #(
    parameter int N_DATA  = 22,
    parameter int NB_ADDR = 10
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_run_log,
    input  logic               i_read_log,
    input  logic [NB_ADDR-1:0] i_addr_log,
    input  logic [N_DATA-1:0]  i_data,
    input  logic               i_valid,
    output logic [N_DATA-1:0]  o_data_log,
    output logic               o_mem_full,
    output logic               o_logging,
    output logic [1:0]         o_state
);

    localparam int DEPTH = 2 ** NB_ADDR;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOG  = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [NB_ADDR-1:0] wr_ptr;
    logic [NB_ADDR-1:0] wr_ptr_next;
    logic               mem_full_next;
    logic               r_run;
    logic               start;
    logic               wr_en;
    logic               last_write;

    logic [N_DATA-1:0]  mem [DEPTH];

    // Sample handshake: i_valid is a one-cycle strobe with no back-pressure; a sample
    // is taken only in LOG while i_run_log is still high, otherwise it is dropped.
    assign start      = i_run_log & ~r_run;
    assign wr_en      = (state == ST_LOG) & i_run_log & i_valid & ~i_reset;
    assign last_write = wr_en & (wr_ptr == {NB_ADDR{1'b1}});

    always_comb begin
        state_next    = state;
        wr_ptr_next   = wr_ptr;
        mem_full_next = o_mem_full;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next  = ST_LOG;
                    wr_ptr_next = '0;
                end
            end
            ST_LOG: begin
                // Abort wins over a coincident sample so a dropped run never writes.
                if (!i_run_log) begin
                    state_next = ST_IDLE;
                end else if (i_valid) begin
                    wr_ptr_next = wr_ptr + 1'b1;
                    if (last_write) begin
                        state_next    = ST_FULL;
                        mem_full_next = 1'b1;
                    end
                end
            end
            ST_FULL: begin
                if (start) begin
                    state_next    = ST_LOG;
                    mem_full_next = 1'b0;
                    wr_ptr_next   = '0;
                end
            end
            default: begin
                state_next    = ST_IDLE;
                mem_full_next = 1'b0;
                wr_ptr_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            r_run      <= 1'b0;
            o_mem_full <= 1'b0;
        end else begin
            state      <= state_next;
            wr_ptr     <= wr_ptr_next;
            r_run      <= i_run_log;
            o_mem_full <= mem_full_next;
        end
    end

    // RAM array carries no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Reads are gated by the registered full flag, so they can never overlap a capture.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_data_log <= '0;
        end else if (i_read_log && o_mem_full) begin
            o_data_log <= mem[i_addr_log];
        end
    end

    assign o_logging = (state == ST_LOG);
    assign o_state   = state;

endmodule

// File: tb/tb_log_memory_capture.sv
// Bench for log_memory_capture: directed capture/abort/re-arm/reset scenarios checked
// every cycle against a sample-count model, plus literal spot checks.
module tb_log_memory_capture;

    localparam int N_DATA  = 22;
    localparam int NB_ADDR = 10;
    localparam int DEPTH   = 1024;

    logic               clock = 1'b0;
    logic               i_reset;
    logic               i_run_log;
    logic               i_read_log;
    logic [NB_ADDR-1:0] i_addr_log;
    logic [N_DATA-1:0]  i_data;
    logic               i_valid;
    logic [N_DATA-1:0]  o_data_log;
    logic               o_mem_full;
    logic               o_logging;
    logic [1:0]         o_state;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // clock / reset
    always #5 clock = ~clock;

    log_memory_capture #(.N_DATA(N_DATA), .NB_ADDR(NB_ADDR)) dut (
        .clock      (clock),
        .i_reset    (i_reset),
        .i_run_log  (i_run_log),
        .i_read_log (i_read_log),
        .i_addr_log (i_addr_log),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_data_log (o_data_log),
        .o_mem_full (o_mem_full),
        .o_logging  (o_logging),
        .o_state    (o_state)
    );

    // model: a capture is "in progress" with a sample count; full means DEPTH samples held
    logic [N_DATA-1:0] m_mem [DEPTH];
    logic [N_DATA-1:0] m_data;
    bit                m_cap;
    bit                m_full;
    bit                m_prev;
    int                m_cnt;

    always @(posedge clock) begin
        if (i_reset) begin
            m_cap  = 1'b0;
            m_full = 1'b0;
            m_prev = 1'b0;
            m_cnt  = 0;
            m_data = '0;
        end else begin
            if (i_read_log && m_full) m_data = m_mem[i_addr_log];
            if (m_cap) begin
                if (!i_run_log) begin
                    m_cap = 1'b0;
                end else if (i_valid) begin
                    m_mem[m_cnt] = i_data;
                    m_cnt = m_cnt + 1;
                    if (m_cnt == DEPTH) begin
                        m_cap  = 1'b0;
                        m_full = 1'b1;
                    end
                end
            end else if (i_run_log && !m_prev) begin
                m_cap  = 1'b1;
                m_full = 1'b0;
                m_cnt  = 0;
            end
            m_prev = i_run_log;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // scoreboard compare, away from the active edge
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("model_mem_full", 32'(o_mem_full), 32'(m_full));
            chk("model_logging",  32'(o_logging),  32'(m_cap));
            chk("model_data_log", 32'(o_data_log), 32'(m_data));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic sample(input logic [N_DATA-1:0] d);
        i_valid = 1'b1;
        i_data  = d;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic read(input logic [NB_ADDR-1:0] a);
        i_read_log = 1'b1;
        i_addr_log = a;
        tick();
        i_read_log = 1'b0;
    endtask

    task automatic arm();
        i_run_log = 1'b0;
        tick();
        i_run_log = 1'b1;
        tick();
    endtask

    initial begin
        i_reset    = 1'b1;
        i_run_log  = 1'b0;
        i_read_log = 1'b0;
        i_addr_log = '0;
        i_data     = '0;
        i_valid    = 1'b0;

        // 1 reset
        tick();
        cmp_en = 1'b1;
        tick();
        tick();
        chk("reset_full", 32'(o_mem_full), 32'd0);
        chk("reset_logging", 32'(o_logging), 32'd0);
        chk("reset_data", 32'(o_data_log), 32'd0);
        i_reset = 1'b0;
        tick();

        // 2 full capture, back-to-back samples
        i_run_log = 1'b1;
        tick();
        chk("arm_logging", 32'(o_logging), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            sample(N_DATA'(i));
            if (i == DEPTH - 2) chk("full_not_early", 32'(o_mem_full), 32'd0);
        end
        chk("full_after_1024", 32'(o_mem_full), 32'd1);
        chk("full_logging_low", 32'(o_logging), 32'd0);
        read(10'd0);
        chk("rd_addr0", 32'(o_data_log), 32'd0);
        read(10'd511);
        chk("rd_addr511", 32'(o_data_log), 32'd511);
        read(10'd1023);
        chk("rd_addr1023", 32'(o_data_log), 32'd1023);

        // falling run in FULL keeps the capture
        i_run_log = 1'b0;
        tick();
        tick();
        chk("full_hold_run_low", 32'(o_mem_full), 32'd1);

        // 3 sparse valid, re-arm clears full on the next edge
        i_run_log = 1'b1;
        tick();
        chk("rearm_full_clr", 32'(o_mem_full), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("sparse_not_early", 32'(o_mem_full), 32'd0);
            sample(N_DATA'(32'h1000 + i));
            tick();
            tick();
        end
        chk("sparse_full", 32'(o_mem_full), 32'd1);
        read(10'd7);
        chk("sparse_rd7", 32'(o_data_log), 32'h1007);

        // 4 abort after 100 samples; a sample coincident with the abort is dropped
        arm();
        for (int i = 0; i < 100; i++) sample(N_DATA'(32'h2000 + i));
        i_run_log = 1'b0;
        sample(22'h0abc);
        chk("abort_full", 32'(o_mem_full), 32'd0);
        chk("abort_logging", 32'(o_logging), 32'd0);
        read(10'd3);
        chk("abort_read_hold", 32'(o_data_log), 32'h1007);

        // 5 second capture overwrites
        i_run_log = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) sample(N_DATA'(32'h3fffff - i));
        read(10'd5);
        chk("rearm_rd5", 32'(o_data_log), 32'h3ffffa);
        read(10'd100);
        chk("abort_overwritten", 32'(o_data_log), 32'h3fff9b);

        // start and read in the same FULL cycle: old data, then LOG
        i_run_log = 1'b0;
        tick();
        i_run_log  = 1'b1;
        i_read_log = 1'b1;
        i_addr_log = 10'd6;
        tick();
        i_read_log = 1'b0;
        chk("start_read_old", 32'(o_data_log), 32'h3ffff9);
        chk("start_read_full", 32'(o_mem_full), 32'd0);
        chk("start_read_log", 32'(o_logging), 32'd1);

        // 6 overflow pulses in FULL are ignored
        for (int i = 0; i < DEPTH; i++) sample(N_DATA'(i * 3));
        for (int i = 0; i < 8; i++) sample(22'h155555);
        read(10'd0);
        chk("overflow_addr0", 32'(o_data_log), 32'd0);
        read(10'd1);
        chk("overflow_addr1", 32'(o_data_log), 32'd3);

        // reset mid-capture, then a fresh capture starts at address 0
        arm();
        for (int i = 0; i < 50; i++) sample(N_DATA'(32'h100 + i));
        i_run_log = 1'b0;
        i_reset   = 1'b1;
        tick();
        i_reset = 1'b0;
        chk("midreset_full", 32'(o_mem_full), 32'd0);
        chk("midreset_logging", 32'(o_logging), 32'd0);
        chk("midreset_data", 32'(o_data_log), 32'd0);
        i_run_log = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) chk("restart_not_early", 32'(o_mem_full), 32'd0);
            sample(N_DATA'(32'h200000 + i));
        end
        chk("restart_full", 32'(o_mem_full), 32'd1);
        read(10'd0);
        chk("restart_rd0", 32'(o_data_log), 32'h200000);
        read(10'd49);
        chk("restart_rd49", 32'(o_data_log), 32'h200031);
        tick();

        // final report
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
